debug_slave_sysclk_bridge: RTL and testbench

- System-clock half of the on-chip debug slave, generalised. Accepts the virtual-JTAG update strobes (vs_uir, vs_udr) and the TCK-domain shift register and IR as asynchronous inputs.
- Synchronises the strobes and captures each completed DR scan, with its IR, into a small command FIFO.
- Presents commands to the debug core over a valid/ready handshake and emits per-IR take_action / take_no_action pulses on dequeue.
- Unlike the fixed 38-bit, 2-bit-IR, unbuffered predecessor, width, IR size, synchroniser depth and queue depth are all parameters, and back-to-back scans are buffered with overflow reporting.

---
 rtl/debug_slave_sysclk_bridge_pkg.sv | 27 ++
 rtl/debug_slave_sysclk_bridge_if.sv | 22 ++
 rtl/debug_slave_sysclk_bridge_strobe_sync.sv | 32 +++
 rtl/debug_slave_sysclk_bridge.sv | 113 +++++++++++
 tb/tb_debug_slave_sysclk_bridge.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/debug_slave_sysclk_bridge_pkg.sv
// Shared definitions for the debug slave system-clock bridge:
// virtual-IR encodings, the command record and a constant clog2 helper.
package debug_slave_pkg;

   localparam int unsigned DBG_DATA_W = 38;
   localparam int unsigned DBG_IR_W   = 2;

   typedef enum logic [DBG_IR_W-1:0] {
      IR_OCIMEM_A  = 2'd0,
      IR_OCIMEM_B  = 2'd1,
      IR_BREAK     = 2'd2,
      IR_TRACECTRL = 2'd3
   } dbg_ir_e;

   typedef struct packed {
      logic [DBG_IR_W-1:0]   ir;
      logic [DBG_DATA_W-1:0] data;
   } dbg_cmd_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/debug_slave_sysclk_bridge_if.sv
// Command handshake between the bridge (master) and the debug core (slave).
interface debug_slave_sysclk_bridge_if #(
   parameter int unsigned DATA_W = 38,
   parameter int unsigned IR_W   = 2
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [DATA_W-1:0]    cmd_data;
   logic [IR_W-1:0]      cmd_ir;
   logic [2**IR_W-1:0]   take_action;
   logic [2**IR_W-1:0]   take_no_action;

   modport master (
      output cmd_valid, cmd_data, cmd_ir, take_action, take_no_action,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_data, cmd_ir, take_action, take_no_action,
      output cmd_ready
   );
endinterface

// File: rtl/debug_slave_sysclk_bridge_strobe_sync.sv
// Multi-flop synchroniser for an asynchronous strobe with a single-cycle
// rising-edge pulse output.
module debug_slave_strobe_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic [SYNC_STAGES:0]   settle_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q   <= '0;
         edge_q   <= 1'b0;
         settle_q <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], async_in};
         edge_q   <= sync_q[SYNC_STAGES-1];
         settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // Edges are ignored until the real input level has reached edge_q, so a
   // strobe already high at reset release is not mistaken for a new edge.
   assign rise_pulse = settle_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/debug_slave_sysclk_bridge.sv
// System-clock half of the debug slave: synchronises the update strobes,
// queues completed DR scans with their IR and hands them out over valid/ready.
module debug_slave_sysclk_bridge
   import debug_slave_pkg::*;
#(
   parameter int unsigned DATA_W      = 38,
   parameter int unsigned IR_W        = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ACTION_BIT  = DATA_W - 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_W-1:0]           sr_in,
   input  logic [IR_W-1:0]             ir_in,
   input  logic                        vs_uir,
   input  logic                        vs_udr,
   debug_slave_sysclk_bridge_if.master cmd,
   output logic [clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                        overflow,
   input  logic                        overflow_clr
);

   localparam int unsigned AW  = clog2(FIFO_DEPTH);
   localparam int unsigned NCH = 2**IR_W;

   typedef struct packed {
      logic [IR_W-1:0]   ir;
      logic [DATA_W-1:0] data;
   } cmd_t;

   logic           uir_rise, udr_rise;
   logic [IR_W-1:0] ir_latched_q;
   cmd_t           mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wptr_q, rptr_q;
   logic [AW:0]    level_q, level_d;
   logic           overflow_q, overflow_d;
   logic           full, pop, push_ok;
   cmd_t           head;
   logic [NCH-1:0] take_a, take_n;

   debug_slave_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
      .clk        (clk),
      .reset      (reset),
      .async_in   (vs_uir),
      .rise_pulse (uir_rise)
   );

   debug_slave_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
      .clk        (clk),
      .reset      (reset),
      .async_in   (vs_udr),
      .rise_pulse (udr_rise)
   );

   assign head    = mem_q[rptr_q];
   assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
   assign pop     = (level_q != '0) & cmd.cmd_ready;
   // A full queue still accepts the push when the head leaves in the same cycle.
   assign push_ok = udr_rise & (~full | pop);

   always_comb begin
      level_d = level_q;
      if (push_ok & ~pop)
         level_d = level_q + 1'b1;
      else if (pop & ~push_ok)
         level_d = level_q - 1'b1;
      overflow_d = (udr_rise & full & ~pop) | (overflow_q & ~overflow_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_latched_q <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         level_q      <= '0;
         overflow_q   <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         if (uir_rise)
            ir_latched_q <= ir_in;
         if (push_ok) begin
            mem_q[wptr_q] <= '{ir: ir_latched_q, data: sr_in};
            wptr_q        <= wptr_q + 1'b1;
         end
         if (pop)
            rptr_q <= rptr_q + 1'b1;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      take_a = '0;
      take_n = '0;
      if (pop) begin
         if (head.data[ACTION_BIT])
            take_a[head.ir] = 1'b1;
         else
            take_n[head.ir] = 1'b1;
      end
   end

   assign cmd.cmd_valid      = (level_q != '0);
   assign cmd.cmd_data       = head.data;
   assign cmd.cmd_ir         = head.ir;
   assign cmd.take_action    = take_a;
   assign cmd.take_no_action = take_n;
   assign fifo_level         = level_q;
   assign overflow           = overflow_q;

endmodule

// File: tb/tb_debug_slave_sysclk_bridge.sv
// Scoreboard bench for debug_slave_sysclk_bridge with default parameters.
module tb_debug_slave_sysclk_bridge;
   import debug_slave_pkg::*;

   localparam int unsigned S = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] sr_in;
   logic [1:0]  ir_in;
   logic        vs_uir, vs_udr, overflow_clr;
   logic [2:0]  fifo_level;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;
   dbg_cmd_t sb[$];

   debug_slave_sysclk_bridge_if #(.DATA_W(38), .IR_W(2)) cmd_if ();

   debug_slave_sysclk_bridge #(
      .DATA_W(38), .IR_W(2), .SYNC_STAGES(S), .FIFO_DEPTH(4), .ACTION_BIT(37)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sr_in        (sr_in),
      .ir_in        (ir_in),
      .vs_uir       (vs_uir),
      .vs_udr       (vs_udr),
      .cmd          (cmd_if),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ir(input logic [1:0] v);
      ir_in  = v;
      vs_uir = 1'b1;
      tick(3);
      vs_uir = 1'b0;
      tick(S + 3);
   endtask

   task automatic udr_hi(input logic [37:0] d, input logic keep);
      sr_in  = d;
      vs_udr = 1'b1;
      if (keep) sb.push_back('{ir: ir_in, data: d});
   endtask

   task automatic udr_lo();
      vs_udr = 1'b0;
      tick(S + 3);
   endtask

   task automatic scan(input logic [37:0] d, input logic keep);
      udr_hi(d, keep);
      tick(3);
      udr_lo();
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      cmd_if.cmd_ready = 1'b1;
      while (fifo_level != 0 && cyc < 50) begin
         tick(1);
         cyc++;
      end
      cmd_if.cmd_ready = 1'b0;
      tick(1);
      chk("drain_level", fifo_level, 0);
      chk("sb_empty", sb.size(), 0);
   endtask

   // Dequeue monitor: head and take pulses against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_deq", 1, 0);
            end else begin
               dbg_cmd_t e;
               logic [3:0] ea, en;
               e  = sb.pop_front();
               ea = e.data[37] ? (4'b0001 << e.ir) : 4'b0000;
               en = e.data[37] ? 4'b0000 : (4'b0001 << e.ir);
               chk("deq_data", cmd_if.cmd_data, e.data);
               chk("deq_ir", cmd_if.cmd_ir, e.ir);
               chk("take_action", cmd_if.take_action, ea);
               chk("take_no_action", cmd_if.take_no_action, en);
            end
         end else begin
            chk("take_idle", {cmd_if.take_action, cmd_if.take_no_action}, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; sr_in = '0; ir_in = '0; vs_uir = 1'b0; vs_udr = 1'b1;
      overflow_clr = 1'b0; cmd_if.cmd_ready = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(10);
      chk("rst_valid", cmd_if.cmd_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_data", cmd_if.cmd_data, 0);
      chk("rst_take", {cmd_if.take_action, cmd_if.take_no_action}, 0);
      vs_udr = 1'b0;
      tick(S + 3);
      chk("rst_after_low", fifo_level, 0);

      // Single scan with latency measured from the strobe edge.
      set_ir(2'd2);
      udr_hi(38'h20_0000_1234, 1'b1);
      tick(S);
      chk("lat_not_yet", cmd_if.cmd_valid, 0);
      tick(1);
      chk("lat_valid", cmd_if.cmd_valid, 1);
      chk("lat_ir", cmd_if.cmd_ir, 2);
      chk("lat_data", cmd_if.cmd_data, 38'h20_0000_1234);
      chk("lat_level", fifo_level, 1);
      tick(2);
      udr_lo();
      drain();

      // No-action path.
      set_ir(2'd1);
      scan(38'h0_0000_00FF, 1'b1);
      chk("noact_level", fifo_level, 1);
      drain();

      // Fill and overflow: scan 5 must be dropped.
      set_ir(2'd3);
      for (int k = 1; k <= 5; k++) scan(38'(k), k <= 4);
      chk("fill_level", fifo_level, 4);
      chk("fill_overflow", overflow, 1);
      drain();

      // Overflow clear racing a fresh drop: set wins, then clear alone.
      for (int k = 11; k <= 14; k++) scan(38'(k), 1'b1);
      chk("race_full", fifo_level, 4);
      udr_hi(38'h2A_0000_0055, 1'b0);
      tick(S);
      overflow_clr = 1'b1;
      tick(1);
      chk("race_set_wins", overflow, 1);
      chk("race_level", fifo_level, 4);
      tick(1);
      overflow_clr = 1'b0;
      chk("clr_alone", overflow, 0);
      tick(1);
      udr_lo();

      // Full with push and pop landing together.
      udr_hi(38'h3F_0000_0066, 1'b1);
      tick(S);
      cmd_if.cmd_ready = 1'b1;
      tick(1);
      cmd_if.cmd_ready = 1'b0;
      chk("pp_level", fifo_level, 4);
      chk("pp_overflow", overflow, 0);
      tick(2);
      udr_lo();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
